// File: rtl/easy_axis_rr_arbiter.sv
// rtl/easy_axis_rr_arbiter.sv - packet-aware round-robin arbiter onto one AXI-Stream port
module easy_axis_rr_arbiter #(
   parameter int NUM_IN  = 4,
   parameter int DWIDTH  = 32,
   localparam int IDWIDTH = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NUM_IN*DWIDTH-1:0] s_axis_tdata,
   input  logic [NUM_IN-1:0]        s_axis_tvalid,
   input  logic [NUM_IN-1:0]        s_axis_tlast,
   output logic [NUM_IN-1:0]        s_axis_tready,
   output logic [DWIDTH-1:0]        m_axis_tdata,
   output logic                     m_axis_tlast,
   output logic [IDWIDTH-1:0]       m_axis_tid,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   logic [0:0]         state;
   logic [IDWIDTH-1:0] grant;
   logic [IDWIDTH-1:0] last_grant;
   logic [IDWIDTH-1:0] pick;
   logic [IDWIDTH-1:0] idx;
   logic               found;
   int                 cand;
   logic               xfer;
   logic               accept_last;

   // Reset forces every handshake output low regardless of the registered state.
   assign xfer = rstn && (state == XFER);

   // Scan last_grant+1, last_grant+2, ... wrapping at NUM_IN; first valid port wins.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NUM_IN; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= NUM_IN) begin
            cand = cand - NUM_IN;
         end
         idx = IDWIDTH'(cand);
         if (!found && s_axis_tvalid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // Ready is steered to the granted port only; it never looks at any tvalid.
   always_comb begin
      s_axis_tready = '0;
      if (xfer) begin
         s_axis_tready[grant] = m_axis_tready;
      end
   end

   assign m_axis_tvalid = xfer & s_axis_tvalid[grant];
   assign m_axis_tlast  = xfer & s_axis_tlast[grant];
   assign m_axis_tdata  = s_axis_tdata[grant*DWIDTH +: DWIDTH];
   assign m_axis_tid    = rstn ? grant : '0;
   assign accept_last   = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Grant is taken in IDLE and held until the tlast beat is accepted.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IDWIDTH'(NUM_IN - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|s_axis_tvalid) begin
                  grant <= pick;
                  state <= XFER;
               end
            end
            default: begin
               if (accept_last) begin
                  last_grant <= grant;
                  state      <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_easy_axis_rr_arbiter.sv
// tb/tb_easy_axis_rr_arbiter.sv - self-checking bench for easy_axis_rr_arbiter
module tb_easy_axis_rr_arbiter;

   logic        clk;
   logic        rstn;
   logic        sel3;
   logic [3:0]  sv;
   logic [3:0]  sl;
   logic [31:0] sd [4];
   logic        mr;

   logic [3:0]  sr4;
   logic [31:0] md4;
   logic        ml4;
   logic [1:0]  tid4;
   logic        mv4;
   logic [2:0]  sr3;
   logic [31:0] md3;
   logic        ml3;
   logic [1:0]  tid3;
   logic        mv3;

   logic [3:0]  o_sr;
   logic [31:0] o_md;
   logic        o_ml;
   logic [1:0]  o_tid;
   logic        o_mv;

   int n_err;
   int n_checks;

   easy_axis_rr_arbiter #(.NUM_IN(4), .DWIDTH(32)) dut4 (
      .clk           (clk),
      .rstn          (rstn),
      .s_axis_tdata  ({sd[3], sd[2], sd[1], sd[0]}),
      .s_axis_tvalid (sel3 ? 4'b0000 : sv),
      .s_axis_tlast  (sl),
      .s_axis_tready (sr4),
      .m_axis_tdata  (md4),
      .m_axis_tlast  (ml4),
      .m_axis_tid    (tid4),
      .m_axis_tvalid (mv4),
      .m_axis_tready (mr)
   );

   easy_axis_rr_arbiter #(.NUM_IN(3), .DWIDTH(32)) dut3 (
      .clk           (clk),
      .rstn          (rstn),
      .s_axis_tdata  ({sd[2], sd[1], sd[0]}),
      .s_axis_tvalid (sel3 ? sv[2:0] : 3'b000),
      .s_axis_tlast  (sl[2:0]),
      .s_axis_tready (sr3),
      .m_axis_tdata  (md3),
      .m_axis_tlast  (ml3),
      .m_axis_tid    (tid3),
      .m_axis_tvalid (mv3),
      .m_axis_tready (mr)
   );

   assign o_sr  = sel3 ? {1'b0, sr3} : sr4;
   assign o_md  = sel3 ? md3 : md4;
   assign o_ml  = sel3 ? ml3 : ml4;
   assign o_tid = sel3 ? tid3 : tid4;
   assign o_mv  = sel3 ? mv3 : mv4;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rstn;
      logic [3:0] v;
      logic [3:0] l;
      logic       mr;
      logic [3:0] sr;
      logic       mv;
      logic [1:0] tid;
      logic       ml;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic m,
                      input logic [3:0] esr, input logic emv, input logic [1:0] etid, input logic eml);
      vec_t e;
      e.rstn = r; e.v = v; e.l = l; e.mr = m;
      e.sr = esr; e.mv = emv; e.tid = etid; e.ml = eml;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random traffic with a per-port beat scoreboard and an owner/round-robin model.
   task automatic rand_run(input int n, input int cycles);
      int owner, last, pick, t;
      int src_seq[4];
      int src_left[4];
      int exp_seq[4];
      logic [3:0] exp_sr;
      logic       exp_mv;
      logic [3:0] hs;
      sv = '0; sl = '0; mr = 1'b1; rstn = 1'b0;
      tick();
      rstn = 1'b1;
      owner = -1;
      last = n - 1;
      for (int p = 0; p < 4; p++) begin
         src_seq[p] = 0; exp_seq[p] = 0;
         src_left[p] = $urandom_range(1, 4);
         if (p < n) begin
            sv[p] = ($urandom % 2) == 0;
            sd[p] = {8'(p), 24'(src_seq[p])};
            sl[p] = (src_left[p] == 1);
         end
      end
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (owner < 0) begin
            exp_sr = '0;
            exp_mv = 1'b0;
         end else begin
            exp_sr = 4'(mr) << owner;
            exp_mv = sv[owner];
         end
         chk("rnd_ready", o_sr, exp_sr);
         chk("rnd_valid", o_mv, exp_mv);
         if (owner >= 0 && exp_mv) begin
            chk("rnd_tid", o_tid, owner);
            chk("rnd_tlast", o_ml, sl[owner]);
         end
         if (o_mv && mr) begin
            t = int'(o_tid);
            chk("rnd_tid_range", t < n, 1);
            if (t < n) begin
               chk("rnd_beat_order", o_md, {8'(t), 24'(exp_seq[t])});
               exp_seq[t]++;
            end
         end
         if (owner < 0) begin
            pick = -1;
            for (int k = 1; k <= n; k++) begin
               if (pick < 0 && sv[(last + k) % n]) pick = (last + k) % n;
            end
            owner = pick;
         end else if (sv[owner] && mr && sl[owner]) begin
            last = owner;
            owner = -1;
         end
         hs = o_sr & sv;
         tick();
         for (int p = 0; p < n; p++) begin
            if (hs[p]) begin
               src_seq[p]++;
               src_left[p]--;
               if (src_left[p] == 0) src_left[p] = $urandom_range(1, 4);
               sv[p] = ($urandom % 4) != 0;
            end else if (!sv[p]) begin
               sv[p] = ($urandom % 3) == 0;
            end
            sd[p] = {8'(p), 24'(src_seq[p])};
            sl[p] = (src_left[p] == 1);
         end
         mr = ($urandom % 4) != 0;
      end
      sv = '0;
   endtask

   initial begin
      int hs_count, exp_hs;
      n_err = 0;
      n_checks = 0;
      sel3 = 1'b0; rstn = 1'b0; sv = '0; sl = '0; mr = 1'b1;
      for (int p = 0; p < 4; p++) sd[p] = 32'hA000_0000 + 32'(p);

      // reset state
      tick();
      rstn = 1'b1;
      @(negedge clk);
      chk("reset_ready", o_sr, 0);
      chk("reset_valid", o_mv, 0);
      chk("reset_tid", o_tid, 0);
      chk("reset_tlast", o_ml, 0);
      tick();

      // single port 2, 3-beat packet
      add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0100, 4'b0000, 1, 4'b0100, 1, 2, 0);
      add(1, 4'b0100, 4'b0000, 1, 4'b0100, 1, 2, 0);
      add(1, 4'b0100, 4'b0100, 1, 4'b0100, 1, 2, 1);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      // fairness: all ports busy with 2-beat packets
      add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         add(1, 4'b1111, 4'b0000, 1, 4'(1 << (k % 4)), 1, 2'(k % 4), 0);
         add(1, 4'b1111, 4'(1 << (k % 4)), 1, 4'(1 << (k % 4)), 1, 2'(k % 4), 1);
         if (k < 4) add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0);
         else       add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      end
      // no interleave: port 0 stalls mid-packet while port 1 waits
      add(1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0011, 4'b0000, 1, 4'b0001, 1, 0, 0);
      for (int k = 0; k < 5; k++) add(1, 4'b0010, 4'b0000, 1, 4'b0001, 0, 0, 0);
      add(1, 4'b0011, 4'b0001, 1, 4'b0001, 1, 0, 1);
      add(1, 4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      // backpressure on a 4-beat packet from port 3
      add(1, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 3, 0);
      add(1, 4'b1000, 4'b0000, 0, 4'b0000, 1, 3, 0);
      add(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 3, 0);
      add(1, 4'b1000, 4'b0000, 0, 4'b0000, 1, 3, 0);
      add(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 3, 0);
      add(1, 4'b1000, 4'b1000, 0, 4'b0000, 1, 3, 1);
      add(1, 4'b1000, 4'b1000, 1, 4'b1000, 1, 3, 1);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      // mid-packet reset restores port-0 priority
      add(1, 4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 1);
      add(1, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0100, 4'b0000, 1, 4'b0100, 1, 2, 0);
      add(0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0101, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0101, 4'b0001, 1, 4'b0001, 1, 0, 1);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

      hs_count = 0;
      exp_hs = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         rstn = tbl[i].rstn; sv = tbl[i].v; sl = tbl[i].l; mr = tbl[i].mr;
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), o_sr, tbl[i].sr);
         chk($sformatf("vec%0d_valid", i), o_mv, tbl[i].mv);
         if (tbl[i].mv) begin
            chk($sformatf("vec%0d_tid", i), o_tid, tbl[i].tid);
            chk($sformatf("vec%0d_tlast", i), o_ml, tbl[i].ml);
            chk($sformatf("vec%0d_data", i), o_md, 32'hA000_0000 + 32'(tbl[i].tid));
         end
         if (o_mv && mr) hs_count++;
         if (tbl[i].mv && tbl[i].mr) exp_hs++;
         tick();
      end
      chk("vec_beat_count", hs_count, exp_hs);

      // NUM_IN=3 wrap: last grant on port 2, then ports 0 and 1 compete
      sel3 = 1'b1; rstn = 1'b0; sv = '0; sl = '0; mr = 1'b1;
      tick();
      rstn = 1'b1; sv = 4'b0100; sl = 4'b0100;
      @(negedge clk);
      chk("n3_idle_valid", o_mv, 0);
      tick();
      @(negedge clk);
      chk("n3_port2_tid", o_tid, 2);
      chk("n3_port2_ready", o_sr, 4'b0100);
      tick();
      sv = 4'b0011; sl = 4'b0011;
      @(negedge clk);
      chk("n3_gap_valid", o_mv, 0);
      chk("n3_gap_ready", o_sr, 0);
      tick();
      @(negedge clk);
      chk("n3_wrap_tid", o_tid, 0);
      chk("n3_wrap_ready", o_sr, 4'b0001);
      tick();
      sv = 4'b0010; sl = 4'b0010;
      tick();
      @(negedge clk);
      chk("n3_next_tid", o_tid, 1);
      chk("n3_next_valid", o_mv, 1);
      tick();
      sv = '0;
      tick();

      sel3 = 1'b0;
      rand_run(4, 2000);
      sel3 = 1'b1;
      rand_run(3, 2000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
